// File: rtl/buf_readout_ctrl.sv
// Reads one BLK_WORDS block from the sample buffer to the host pipe, padding short blocks after TIMEOUT.
// Latency blk_req -> first host_valid is 3 cycles; no backpressure from host, buffer paced only by buf_count.
module buf_readout_ctrl #(
    parameter int          BLK_WORDS = 256,
    parameter int          TIMEOUT   = 1000,
    parameter logic [31:0] PAD_WORD  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        blk_req,
    input  logic [10:0] buf_count,
    output logic        buf_rd_en,
    input  logic [31:0] buf_dout,
    output logic        buf_zero,
    output logic        host_valid,
    output logic [31:0] host_data,
    output logic        blk_done,
    output logic        busy,
    output logic [15:0] short_cnt
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [10:0]   BLK      = 11'(BLK_WORDS);

    typedef enum logic [2:0] {IDLE, WAIT, READ, PAD, DONE} state_t;

    state_t        state_q, state_d;
    logic [10:0]   word_cnt_q, word_cnt_d;
    logic [10:0]   n_lim_q, n_lim_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          short_q, short_d;
    logic [15:0]   short_cnt_q;
    logic          rd_en, pad_en;
    logic          hv_q, pad_q, rst_q;
    logic [10:0]   remaining;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        n_lim_d    = n_lim_q;
        tmo_d      = tmo_q;
        short_d    = short_q;
        rd_en      = 1'b0;
        pad_en     = 1'b0;
        remaining  = n_lim_q - word_cnt_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (blk_req) begin
                    state_d    = WAIT;
                    word_cnt_d = '0;
                    tmo_d      = '0;
                    short_d    = 1'b0;
                end
            end
            WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (buf_count >= BLK) begin
                    n_lim_d = BLK;
                    state_d = READ;
                end else if (tmo_q == TMO_LAST) begin
                    n_lim_d = buf_count;
                    short_d = 1'b1;
                    state_d = (buf_count == 11'd0) ? PAD : READ;
                end
            end
            READ: begin
                // Extra READ cycle with nothing issued lets the last word drain before DONE.
                if (word_cnt_q == BLK) begin
                    state_d = DONE;
                end else if (word_cnt_q >= n_lim_q || buf_count < remaining) begin
                    // Buffer shrank under us (rewind): pad from this very cycle so there is no gap.
                    pad_en     = 1'b1;
                    short_d    = 1'b1;
                    word_cnt_d = word_cnt_q + 11'd1;
                    state_d    = PAD;
                end else begin
                    rd_en      = 1'b1;
                    word_cnt_d = word_cnt_q + 11'd1;
                    if (word_cnt_q + 11'd1 == n_lim_q && n_lim_q != BLK)
                        state_d = PAD;
                end
            end
            PAD: begin
                if (word_cnt_q == BLK) begin
                    state_d = DONE;
                end else begin
                    pad_en     = 1'b1;
                    word_cnt_d = word_cnt_q + 11'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            n_lim_q     <= '0;
            tmo_q       <= '0;
            short_q     <= 1'b0;
            short_cnt_q <= '0;
            hv_q        <= 1'b0;
            pad_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            n_lim_q    <= n_lim_d;
            tmo_q      <= tmo_d;
            short_q    <= short_d;
            hv_q       <= rd_en | pad_en;
            pad_q      <= pad_en;
            if (state_q == DONE && short_q && short_cnt_q != 16'hFFFF)
                short_cnt_q <= short_cnt_q + 16'd1;
        end
    end

    // Outputs are forced low while rst is high, which also drops any read already in flight.
    assign buf_rd_en  = rd_en & ~rst;
    assign host_valid = hv_q & ~rst;
    assign host_data  = (hv_q & ~rst) ? (pad_q ? PAD_WORD : buf_dout) : 32'd0;
    assign blk_done   = (state_q == DONE) & ~rst;
    assign busy       = (state_q != IDLE) & ~rst;
    assign short_cnt  = rst ? 16'd0 : short_cnt_q;
    assign buf_zero   = rst_q & ~rst;

endmodule

// File: tb/tb_buf_readout_ctrl.sv
// Bench for buf_readout_ctrl: per-block timeline model against a simple sample-buffer model.
module tb_buf_readout_ctrl;
    localparam int          B    = 4;
    localparam int          T    = 8;
    localparam logic [31:0] PADW = 32'hFFFF_FFFF;

    logic        clk = 1'b0, rst = 1'b1, blk_req = 1'b0;
    logic [10:0] buf_count = '0;
    logic [31:0] buf_dout = '0;
    logic        buf_rd_en, buf_zero, host_valid, blk_done, busy;
    logic [31:0] host_data;
    logic [15:0] short_cnt;

    logic        clk2 = 1'b0, rst2 = 1'b1, blk_req2 = 1'b0;
    logic [10:0] buf_count2 = '0;
    logic [31:0] buf_dout2 = '0;
    logic        buf_rd_en2, buf_zero2, host_valid2, blk_done2, busy2;
    logic [31:0] host_data2;
    logic [15:0] short_cnt2;

    int          tests = 0, fails = 0;
    logic [31:0] mem [64];
    int          ptr = 0, level = 0;
    logic [15:0] exp_short = '0;
    logic        exp_bz = 1'b0;

    always #5 clk = ~clk;
    always #1 clk2 = ~clk2;

    buf_readout_ctrl #(.BLK_WORDS(B), .TIMEOUT(T), .PAD_WORD(PADW)) dut (
        .clk(clk), .rst(rst), .blk_req(blk_req), .buf_count(buf_count),
        .buf_rd_en(buf_rd_en), .buf_dout(buf_dout), .buf_zero(buf_zero),
        .host_valid(host_valid), .host_data(host_data), .blk_done(blk_done),
        .busy(busy), .short_cnt(short_cnt)
    );

    buf_readout_ctrl #(.BLK_WORDS(1), .TIMEOUT(1), .PAD_WORD(PADW)) dut_sat (
        .clk(clk2), .rst(rst2), .blk_req(blk_req2), .buf_count(buf_count2),
        .buf_rd_en(buf_rd_en2), .buf_dout(buf_dout2), .buf_zero(buf_zero2),
        .host_valid(host_valid2), .host_data(host_data2), .blk_done(blk_done2),
        .busy(busy2), .short_cnt(short_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: inputs already set, sample at negedge, then let the buffer answer any read.
    task automatic cycle(input logic e_rd, input logic e_hv, input logic [31:0] e_hd,
                         input logic e_done, input logic e_busy);
        logic rd;
        buf_count = 11'(level);
        @(negedge clk);
        chk("buf_rd_en", buf_rd_en, e_rd);
        chk("host_valid", host_valid, e_hv);
        chk("host_data", host_data, e_hd);
        chk("blk_done", blk_done, e_done);
        chk("busy", busy, e_busy);
        chk("short_cnt", short_cnt, exp_short);
        chk("buf_zero", buf_zero, exp_bz);
        rd = buf_rd_en;
        @(posedge clk);
        #1;
        if (rd) begin
            buf_dout = mem[ptr];
            ptr = (ptr + 1) % 64;
            if (level > 0) level--;
        end
        blk_req = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic start();
        blk_req = 1'b1;
        idle();
    endtask

    // Cycle k=0 is the request cycle (already run); this covers k=1 .. DONE.
    task automatic run_block(input int ign, input bit chain, input int cut);
        int n, s, e, base, i;
        bit sh, cut_on;
        logic [31:0] hd;
        base = ptr;
        if (level >= B) begin n = B; s = 2; end
        else            begin n = level; s = 1 + T; end
        cut_on = (cut >= 0 && cut < n);
        if (cut_on) n = cut;
        sh = (n < B);
        e  = s + B + 1;
        for (int k = 1; k <= e; k++) begin
            if (cut_on && k == s + cut) level = 0;
            blk_req = (k == ign) || (chain && k == e);
            i  = k - s - 1;
            hd = (k >= s + 1 && k <= s + B) ? ((i < n) ? mem[(base + i) % 64] : PADW) : 32'd0;
            cycle(k >= s && k < s + n, k >= s + 1 && k <= s + B, hd, k == e, 1'b1);
        end
        if (sh && exp_short != 16'hFFFF) exp_short++;
    endtask

    initial begin
        int dn, cyc, ign, cut, saved;
        bit chain, prev_chain;
        for (int j = 0; j < 64; j++) mem[j] = $urandom;

        exp_short = '0;
        repeat (3) idle();
        rst = 1'b0;
        exp_bz = 1'b1; idle();
        exp_bz = 1'b0; idle();

        level = 10; start(); run_block(0, 0, -1); idle();
        level = 2;  start(); run_block(0, 0, -1); idle();
        level = 0;  start(); run_block(0, 0, -1); idle();
        level = 20; start(); run_block(4, 1, -1); run_block(0, 0, -1); idle();
        level = 10; start(); run_block(0, 0, 2); idle();

        prev_chain = 0;
        for (int r = 0; r < 16; r++) begin
            ign   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 6)) : 0;
            cut   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            chain = (r != 15) && ($urandom_range(0, 2) == 0);
            if (!prev_chain) begin
                level = $urandom_range(0, 9);
                start();
            end
            run_block(ign, chain, cut);
            prev_chain = chain;
            if (!chain) idle();
        end

        // Reset landing on the second READ cycle aborts the block.
        level = 10; start();
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        rst = 1'b1; exp_short = '0;
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        rst = 1'b0;
        exp_bz = 1'b1; idle();
        exp_bz = 1'b0; idle();
        level = 5; start(); run_block(0, 0, -1); idle();

        // Saturation on a 1-word, 1-cycle-timeout instance with an always-empty buffer.
        repeat (3) @(negedge clk2);
        rst2 = 1'b0;
        blk_req2 = 1'b1;
        dn = 0; cyc = 0;
        while (dn < 65537 && cyc < 300000) begin
            @(negedge clk2);
            cyc++;
            if (blk_done2) begin
                dn++;
                saved = (dn - 1 > 65535) ? 65535 : dn - 1;
                if (dn == 1 || dn == 65535 || dn == 65536 || dn == 65537)
                    chk("short_cnt_sat", short_cnt2, saved);
            end
        end
        if (dn < 65537) chk("sat_timeout_blocks", dn, 65537);
        blk_req2 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
